// File: rtl/motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : motor_pkg                                                        |
// | Purpose : Shared motor-command definitions: command width, sequencer       |
// |           state encoding and the slew-limit step helper. Also imported by  |
// |           the PWM generator for CMD_W.                                     |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package motor_pkg;

  localparam int CMD_W = 10;

  localparam logic [CMD_W-1:0] CMD_MAX     = {CMD_W{1'b1}};
  localparam logic [CMD_W:0]   CMD_MAX_EXT = {1'b0, {CMD_W{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } motor_seq_state_t;

  // One slew-limited step from cur toward tgt. The step is the smaller of the
  // remaining distance and the step limit, so the result never passes tgt.
  // The sum is formed one bit wider and clamped to full scale.
  function automatic logic [CMD_W-1:0] slew_step(
    input logic [CMD_W-1:0] cur,
    input logic [CMD_W-1:0] tgt,
    input logic [CMD_W:0]   up,
    input logic [CMD_W:0]   down
  );
    logic [CMD_W:0] diff;
    logic [CMD_W:0] step;
    logic [CMD_W:0] sum;
    slew_step = cur;
    diff      = '0;
    step      = '0;
    sum       = {1'b0, cur};
    if (cur < tgt) begin
      diff      = {1'b0, tgt} - {1'b0, cur};
      step      = (diff < up) ? diff : up;
      sum       = {1'b0, cur} + step;
      slew_step = (sum > CMD_MAX_EXT) ? CMD_MAX : sum[CMD_W-1:0];
    end else if (cur > tgt) begin
      diff      = {1'b0, cur} - {1'b0, tgt};
      step      = (diff < down) ? diff : down;
      sum       = {1'b0, cur} - step;
      slew_step = sum[CMD_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_tick_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ramp_tick_divider                                                |
// | Purpose : Free-running divider producing a one-cycle tick every TICK_DIV   |
// |           clocks. Counter runs 0..TICK_DIV-1; tick is high while the       |
// |           counter sits at TICK_DIV-1, so the first tick is sampled on the  |
// |           TICK_DIV-th clock edge after reset release.                      |
// | Ports   : CLOCK_50 (in)  system clock                                      |
// |           reset    (in)  synchronous, active-high                          |
// |           tick     (out) one-cycle pulse                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ramp_tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/motor_command_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : motor_command_sequencer                                          |
// | Purpose : Sequences the 10-bit motor duty command from the accelerometer   |
// |           filter to the PWM generator: asymmetric slew limiting, brake /   |
// |           enable override, deadband and (optionally) a stale-sample        |
// |           watchdog with a FAULT state.                                     |
// | Config  : MOTOR_SEQ_WDT_EN defined   -> watchdog and FAULT present.        |
// |           MOTOR_SEQ_WDT_EN undefined -> no watchdog, fault tied 0, the     |
// |                                         last target is held forever.       |
// | Ports   : CLOCK_50    (in)  50 MHz clock                                   |
// |           reset       (in)  synchronous, active-high                       |
// |           accel_valid (in)  filter sample valid                            |
// |           accel_cmd   (in)  filter throttle sample [CMD_W]                 |
// |           accel_ready (out) sample accepted when valid && ready            |
// |           brake       (in)  forces command to 0 next clock                 |
// |           enable      (in)  0 forces command to 0 next clock               |
// |           pwm_cmd     (out) registered duty command [CMD_W]                |
// |           ramping     (out) state is RAMP_UP or RAMP_DOWN                  |
// |           fault       (out) state is FAULT                                 |
// |           state       (out) state encoding [3]                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module motor_command_sequencer
  import motor_pkg::*;
#(
  parameter int STEP_UP   = 4,
  parameter int STEP_DOWN = 16,
  parameter int TICK_DIV  = 50000,
  parameter int DEADBAND  = 8,
  parameter int WDT_TICKS = 100
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             accel_valid,
  input  logic [CMD_W-1:0] accel_cmd,
  output logic             accel_ready,
  input  logic             brake,
  input  logic             enable,
  output logic [CMD_W-1:0] pwm_cmd,
  output logic             ramping,
  output logic             fault,
  output logic [2:0]       state
);

  localparam logic [CMD_W:0]   STEP_UP_C   = (CMD_W+1)'(STEP_UP);
  localparam logic [CMD_W:0]   STEP_DOWN_C = (CMD_W+1)'(STEP_DOWN);
  localparam logic [CMD_W-1:0] DEADBAND_C  = CMD_W'(DEADBAND);

  logic             tick;
  logic             accept;
  logic             override;
  logic             wdt_expire;
  logic [CMD_W-1:0] eff_target;

  logic [CMD_W-1:0] target_q, target_d;
  logic [CMD_W-1:0] pwm_q,    pwm_d;
  motor_seq_state_t state_q,  state_d;
  logic             ramping_q, ramping_d;

  ramp_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  assign accept     = accel_valid && accel_ready;
  assign override   = brake || !enable;
  // The latched target survives an override; only the effective value drops.
  assign eff_target = override ? '0 : target_q;

`ifdef MOTOR_SEQ_WDT_EN
  localparam int               WDT_W    = (WDT_TICKS > 1) ? $clog2(WDT_TICKS) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TICKS - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             fault_q;

  // An accepted sample takes priority over an expiry on the same tick.
  always_comb begin
    wdt_d      = wdt_q;
    wdt_expire = 1'b0;
    if (!enable || (state_q == ST_FAULT) || accept) begin
      wdt_d = '0;
    end else if (tick) begin
      if (wdt_q == WDT_LAST) begin
        wdt_expire = 1'b1;
        wdt_d      = '0;
      end else begin
        wdt_d = wdt_q + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wdt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign accel_ready = !reset && (state_q != ST_FAULT);
  assign fault       = fault_q;
`else
  assign wdt_expire  = 1'b0;
  assign accel_ready = !reset;
  assign fault       = 1'b0;
`endif

  // Next command and state. The state decision looks at the command value
  // being registered this cycle so state and pwm_cmd change together.
  always_comb begin
    target_d = target_q;
    pwm_d    = pwm_q;
    state_d  = state_q;

    if (accept) begin
      target_d = (accel_cmd < DEADBAND_C) ? '0 : accel_cmd;
    end

    if (state_q == ST_FAULT) begin
      target_d = '0;
      pwm_d    = '0;
      state_d  = enable ? ST_FAULT : ST_IDLE;
    end else if (wdt_expire) begin
      target_d = '0;
      pwm_d    = '0;
      state_d  = ST_FAULT;
    end else begin
      if (override) begin
        pwm_d = '0;
      end else if (tick) begin
        pwm_d = slew_step(pwm_q, eff_target, STEP_UP_C, STEP_DOWN_C);
      end

      if ((pwm_d == '0) && (eff_target == '0)) begin
        state_d = ST_IDLE;
      end else if (pwm_d < eff_target) begin
        state_d = ST_RAMP_UP;
      end else if (pwm_d > eff_target) begin
        state_d = ST_RAMP_DOWN;
      end else begin
        state_d = ST_HOLD;
      end
    end

    ramping_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      target_q  <= '0;
      pwm_q     <= '0;
      state_q   <= ST_IDLE;
      ramping_q <= 1'b0;
    end else begin
      target_q  <= target_d;
      pwm_q     <= pwm_d;
      state_q   <= state_d;
      ramping_q <= ramping_d;
    end
  end

  assign pwm_cmd = pwm_q;
  assign ramping = ramping_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_command_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_motor_command_sequencer                                       |
// | Purpose : Scoreboard bench for motor_command_sequencer with TICK_DIV=4     |
// |           and WDT_TICKS=3. Watchdog scenarios depend on MOTOR_SEQ_WDT_EN.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_motor_command_sequencer;
  import motor_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int STEP_UP   = 4;
  localparam int STEP_DOWN = 16;
  localparam int DEADBAND  = 8;
  localparam int WDT_TICKS = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             accel_valid;
  logic [CMD_W-1:0] accel_cmd;
  logic             accel_ready;
  logic             brake;
  logic             enable;
  logic [CMD_W-1:0] pwm_cmd;
  logic             ramping;
  logic             fault;
  logic [2:0]       state;

  always #10 clk = ~clk;

  motor_command_sequencer #(
    .STEP_UP   (STEP_UP),
    .STEP_DOWN (STEP_DOWN),
    .TICK_DIV  (TICK_DIV),
    .DEADBAND  (DEADBAND),
    .WDT_TICKS (WDT_TICKS)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .accel_valid (accel_valid),
    .accel_cmd   (accel_cmd),
    .accel_ready (accel_ready),
    .brake       (brake),
    .enable      (enable),
    .pwm_cmd     (pwm_cmd),
    .ramping     (ramping),
    .fault       (fault),
    .state       (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pwm_cmd values, in order of appearance.
  int         sb_q[$];
  logic [9:0] prev_pwm;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && (pwm_cmd !== prev_pwm)) begin
      if (sb_q.size() == 0) begin
        check("pwm_unexpected_change", {22'd0, pwm_cmd}, {22'd0, prev_pwm});
      end else begin
        check("pwm_seq", {22'd0, pwm_cmd}, sb_q.pop_front());
      end
      prev_pwm = pwm_cmd;
    end
  end

  // Tick phase reference: a tick is sampled on the edge after phase==TICK_DIV-1.
  int phase;
  always @(posedge clk) begin
    if (reset) phase <= 0;
    else       phase <= (phase == TICK_DIV - 1) ? 0 : phase + 1;
  end

  task automatic push_ramp(input int from, input int to);
    int cur;
    cur = from;
    while (cur != to) begin
      if (cur < to) cur = cur + (((to - cur) < STEP_UP) ? (to - cur) : STEP_UP);
      else          cur = cur - (((cur - to) < STEP_DOWN) ? (cur - to) : STEP_DOWN);
      if (cur > 1023) cur = 1023;
      sb_q.push_back(cur);
    end
  endtask

  task automatic wait_done(input motor_seq_state_t exp_st, input string tag, input int bound);
    int n;
    n = 0;
    while (((sb_q.size() != 0) || (state !== exp_st)) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_state"}, {29'd0, state}, {29'd0, exp_st});
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  task automatic wait_pwm(input int val, input string tag, input int bound);
    int n;
    n = 0;
    while ((pwm_cmd !== val[9:0]) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(tag, {22'd0, pwm_cmd}, val);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; accel_valid = 1'b0; accel_cmd = '0; brake = 1'b0; enable = 1'b1;
    prev_pwm = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm",     {22'd0, pwm_cmd}, 0);
    check("rst_state",   {29'd0, state},   0);
    check("rst_ramping", {31'd0, ramping}, 0);
    check("rst_fault",   {31'd0, fault},   0);
    check("rst_ready",   {31'd0, accel_ready}, 0);
    mon_en = 1'b1;
    reset  = 1'b0;

    // Step up 0 -> 100, valid held high so the watchdog stays refreshed.
    accel_valid = 1'b1; accel_cmd = 10'd100;
    push_ramp(0, 100);
    wait_pwm(4, "up_first_step", 40);
    check("up_ramping", {31'd0, ramping}, 1);
    check("up_state",   {29'd0, state},   ST_RAMP_UP);
    wait_done(ST_HOLD, "up", 400);
    check("up_pwm",       {22'd0, pwm_cmd}, 100);
    check("up_ramping_0", {31'd0, ramping}, 0);

    // Step down 100 -> 10, last step shorter than STEP_DOWN.
    accel_cmd = 10'd10;
    push_ramp(100, 10);
    @(negedge clk); @(negedge clk);
    check("down_state", {29'd0, state}, ST_RAMP_DOWN);
    wait_done(ST_HOLD, "down", 200);
    check("down_pwm", {22'd0, pwm_cmd}, 10);

    // Up to 40, then a sub-deadband sample ramps to IDLE.
    accel_cmd = 10'd40;
    push_ramp(10, 40);
    wait_done(ST_HOLD, "to40", 200);
    accel_cmd = 10'd5;
    push_ramp(40, 0);
    wait_done(ST_IDLE, "deadband", 200);
    check("deadband_pwm", {22'd0, pwm_cmd}, 0);

    // Brake from HOLD at 200, then re-ramp from 0.
    accel_cmd = 10'd200;
    push_ramp(0, 200);
    wait_done(ST_HOLD, "to200", 600);
    brake = 1'b1;
    sb_q.push_back(0);
    @(negedge clk);
    check("brake_pwm",   {22'd0, pwm_cmd}, 0);
    check("brake_state", {29'd0, state},   ST_IDLE);
    repeat (6) @(negedge clk);
    check("brake_held", {22'd0, pwm_cmd}, 0);
    brake = 1'b0;
    push_ramp(0, 200);
    wait_done(ST_HOLD, "rebrake", 600);

    // Brake coincident with a new sample: forced to 0, new target latched.
    brake = 1'b1; accel_cmd = 10'd60;
    sb_q.push_back(0);
    @(negedge clk);
    check("race_brake_pwm", {22'd0, pwm_cmd}, 0);
    repeat (3) @(negedge clk);
    brake = 1'b0;
    push_ramp(0, 60);
    wait_done(ST_HOLD, "race_brake", 300);
    check("race_brake_target", {22'd0, pwm_cmd}, 60);

    // enable=0 override.
    enable = 1'b0;
    sb_q.push_back(0);
    @(negedge clk);
    check("enable_pwm",   {22'd0, pwm_cmd}, 0);
    check("enable_state", {29'd0, state},   ST_IDLE);
    enable = 1'b1;
    push_ramp(0, 60);
    wait_done(ST_HOLD, "reenable", 300);

`ifdef MOTOR_SEQ_WDT_EN
    begin
      int n;
      int tk;
      // Stale samples: FAULT after WDT_TICKS ticks.
      accel_valid = 1'b0;
      sb_q.push_back(0);
      n = 0;
      while ((fault !== 1'b1) && (n < 40)) begin
        @(negedge clk);
        n++;
      end
      check("wdt_fault",  {31'd0, fault},       1);
      check("wdt_pwm",    {22'd0, pwm_cmd},     0);
      check("wdt_ready",  {31'd0, accel_ready}, 0);
      check("wdt_state",  {29'd0, state},       ST_FAULT);
      repeat (5) @(negedge clk);
      check("wdt_sticky", {29'd0, state},       ST_FAULT);
      enable = 1'b0;
      @(negedge clk);
      check("wdt_exit_state", {29'd0, state}, ST_IDLE);
      check("wdt_exit_fault", {31'd0, fault}, 0);
      enable = 1'b1;

      // Sample lands on the very tick that would expire the watchdog.
      tk = 0;
      for (int i = 0; (i < 40) && (tk < 3); i++) begin
        if (phase == TICK_DIV - 1) begin
          tk++;
          if (tk == 3) begin
            accel_valid = 1'b1;
            accel_cmd   = 10'd0;
          end
        end
        @(negedge clk);
      end
      accel_valid = 1'b0;
      check("race_wdt_fault", {31'd0, fault},       0);
      check("race_wdt_ready", {31'd0, accel_ready}, 1);
      check("race_wdt_state", {29'd0, state},       ST_IDLE);
    end
`else
    // Without the watchdog the last target is held indefinitely.
    accel_valid = 1'b0;
    repeat (12 * TICK_DIV) @(negedge clk);
    check("nowdt_fault", {31'd0, fault},       0);
    check("nowdt_pwm",   {22'd0, pwm_cmd},     60);
    check("nowdt_state", {29'd0, state},       ST_HOLD);
    check("nowdt_ready", {31'd0, accel_ready}, 1);
    accel_valid = 1'b1; accel_cmd = 10'd0;
    push_ramp(60, 0);
    wait_done(ST_IDLE, "nowdt_down", 200);
`endif

    // Reset mid-ramp at 48.
    accel_valid = 1'b1; accel_cmd = 10'd200;
    push_ramp(0, 48);
    wait_pwm(48, "mid_ramp_48", 100);
    reset = 1'b1; accel_cmd = 10'd8;
    sb_q.push_back(0);
    @(negedge clk);
    check("rst_mid_pwm",     {22'd0, pwm_cmd},     0);
    check("rst_mid_state",   {29'd0, state},       ST_IDLE);
    check("rst_mid_ramping", {31'd0, ramping},     0);
    check("rst_mid_ready",   {31'd0, accel_ready}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Tick counter restarted: first step on the TICK_DIV-th edge after release.
    // 8 equals DEADBAND and so is not suppressed.
    push_ramp(0, 8);
    repeat (3) @(negedge clk);
    check("restart_no_early_tick", {22'd0, pwm_cmd}, 0);
    @(negedge clk);
    check("restart_first_tick", {22'd0, pwm_cmd}, 4);
    wait_done(ST_HOLD, "restart", 100);
    check("deadband_edge_pwm", {22'd0, pwm_cmd}, 8);

    // One below the deadband is treated as 0.
    accel_cmd = 10'd7;
    push_ramp(8, 0);
    wait_done(ST_IDLE, "deadband_7", 100);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
